// File: rtl/ram_byte_sequencer.sv
// ram_byte_sequencer: splits byte/half/word CPU requests into little-endian 8-bit RAM accesses
// and reassembles load bytes into a sign/zero-extended 32-bit response.
module ram_byte_sequencer #(
    parameter int RD_LATENCY = 2,
    parameter int MEM_BYTES  = 1536
) (
    input  logic        CLK_c,
    input  logic        RESET_N_c,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [10:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        RE_c,
    output logic [10:0] RADDR_c,
    output logic        WE_c,
    output logic [10:0] WADDR_c,
    output logic [7:0]  WDATA_c,
    input  logic [7:0]  RDATA_c
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;
    state_t                state;
    logic                  we, uns, bad, rd_hit;
    logic [10:0]           addr;
    logic [1:0]            size, cnt, cap, last, req_last, nxt;
    logic [31:0]           wdata, rdata, cap_data, ext_data;
    logic [11:0]           req_end;
    logic [RD_LATENCY-1:0] tag;

    // last byte index is {size[1], |size}: 00->0, 01->1, 10->3
    always_comb begin
        last     = {size[1], |size};
        req_last = {req_size[1], |req_size};
        req_end  = {1'b0, req_addr} + {10'd0, req_last};
        bad      = (req_size == 2'b11) || (req_end >= 12'(MEM_BYTES));
        nxt      = cnt + 2'd1;
        rd_hit   = tag[RD_LATENCY-1];
        cap_data = rdata;
        cap_data[{cap, 3'b000} +: 8] = RDATA_c;
        ext_data = size == 2'b00 ? {{24{~uns & cap_data[7]}}, cap_data[7:0]} :
                   size == 2'b01 ? {{16{~uns & cap_data[15]}}, cap_data[15:0]} : cap_data;
    end

    always_ff @(posedge CLK_c or negedge RESET_N_c) begin
        if (!RESET_N_c) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            RE_c       <= 1'b0;
            RADDR_c    <= '0;
            WE_c       <= 1'b0;
            WADDR_c    <= '0;
            WDATA_c    <= '0;
            we         <= 1'b0;
            uns        <= 1'b0;
            addr       <= '0;
            size       <= '0;
            wdata      <= '0;
            cnt        <= '0;
            cap        <= '0;
            rdata      <= '0;
            tag        <= '0;
        end else begin
            tag        <= (tag << 1) | RD_LATENCY'(RE_c);
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            RE_c       <= 1'b0;
            RADDR_c    <= '0;
            WE_c       <= 1'b0;
            WADDR_c    <= '0;
            WDATA_c    <= '0;
            if (rd_hit) begin
                rdata <= cap_data;
                cap   <= cap + 2'd1;
            end
            case (state)
                IDLE: if (req_valid) begin
                    we        <= req_we;
                    uns       <= req_unsigned;
                    addr      <= req_addr;
                    size      <= req_size;
                    wdata     <= req_wdata;
                    cnt       <= '0;
                    cap       <= '0;
                    rdata     <= '0;
                    req_ready <= 1'b0;
                    if (bad) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end else begin
                        state   <= ISSUE;
                        RADDR_c <= req_addr;
                        RE_c    <= ~req_we;
                        WE_c    <= req_we;
                        WADDR_c <= req_we ? req_addr : '0;
                        WDATA_c <= req_we ? req_wdata[7:0] : '0;
                    end
                end
                ISSUE: if (cnt == last) begin
                    state      <= we ? RESP : DRAIN;
                    resp_valid <= we;
                end else begin
                    cnt     <= nxt;
                    RADDR_c <= addr + {9'd0, nxt};
                    RE_c    <= ~we;
                    WE_c    <= we;
                    WADDR_c <= we ? addr + {9'd0, nxt} : '0;
                    WDATA_c <= we ? wdata[{nxt, 3'b000} +: 8] : '0;
                end
                DRAIN: if (rd_hit && cap == last) begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= ext_data;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ram_byte_sequencer.md
Name: ram_byte_sequencer

Overview:
- Load/store-side initiator for the 1536x8 banked block RAM; bridges the CPU's byte/half/word memory requests onto the RAM's 8-bit read/write ports.
- Splits each request into 1, 2 or 4 consecutive byte accesses, issued on consecutive cycles, little-endian.
- Reassembles read bytes into a 32-bit result with sign or zero extension and returns one response per request.
- Sits between the CPU memory stage and the RAM instance.

Parameters:
- RD_LATENCY, 2: cycles from driving RE_c/RADDR_c to the matching byte being valid on RDATA_c (RAM primitive plus output register).
- MEM_BYTES, 1536: highest legal byte address + 1.

Ports:
- CLK_c  in  1  single clock; RAM read and write clocks are tied to it.
- RESET_N_c  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  11  byte address of the lowest byte.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal.
- req_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
- req_wdata  in  32  store data; low N bytes are used.
- resp_valid  out  1  single-cycle response pulse.
- resp_err  out  1  request rejected; qualified by resp_valid.
- resp_rdata  out  32  assembled load data; 0 for stores and errors.
- RE_c  out  1  RAM read enable.
- RADDR_c  out  11  RAM read address.
- WE_c  out  1  RAM write enable.
- WADDR_c  out  11  RAM write address.
- WDATA_c  out  8  RAM write byte.
- RDATA_c  in  8  RAM read byte.

Behaviour:
- Reset (asynchronous, RESET_N_c=0):
  - State returns to IDLE; any in-flight request is discarded with no response.
  - All outputs are 0 except req_ready, which is 1.
  - The byte counter and capture register are cleared.
- Transfer size: N = 1, 2 or 4 for req_size 00, 01, 10.
- States: IDLE, ISSUE, DRAIN, RESP.
- IDLE:
  - req_ready=1 in this state only.
  - Accept on req_valid&&req_ready at edge T; latch all req_* fields.
  - If req_size=11, or req_addr+N-1 >= MEM_BYTES (computed 12-bit, no wrap), go to RESP with error.
  - Otherwise go to ISSUE.
- ISSUE, cycles T+1 .. T+N, byte k issued in cycle T+1+k:
  - Load: RE_c=1, RADDR_c=addr+k, WE_c=0.
  - Store: WE_c=1, WADDR_c=addr+k, WDATA_c=wdata[8k+7:8k].
  - Store: RADDR_c also = addr+k, because bank select in the RAM decodes RADDR_c; RE_c stays 0.
  - Misaligned addresses are legal; no alignment check.
- DRAIN (loads only):
  - Byte k is sampled from RDATA_c at the end of cycle T+1+k+RD_LATENCY into rdata[8k+7:8k].
  - This overlaps ISSUE; DRAIN ends once byte N-1 is captured.
  - A shift-register tag of depth RD_LATENCY tracks valid issued reads.
- RESP:
  - One cycle with resp_valid=1, then back to IDLE.
  - The next request can be accepted in the cycle after RESP.
- Response timing:
  - Load: resp_valid in cycle T+N+RD_LATENCY+1 (word, RD_LATENCY=2: T+7).
  - Store: T+N+1.
  - Error: T+1.
- Load extension:
  - Result bits above 8N are filled with bit 8N-1 of the assembled value if req_unsigned=0, else with 0.
  - Word loads ignore req_unsigned.
- Error response: resp_err=1, resp_rdata=0; no RE_c or WE_c strobe is ever issued for an errored request.
- When not in ISSUE: RE_c=WE_c=0; addresses and WDATA_c hold 0.
- req_valid while busy is ignored (req_ready=0); the requester must hold its request.
- Reset mid-ISSUE: WE_c drops asynchronously.
  - Bytes already written stay written; no partial response.
  - The pending read pipeline is flushed.

Test Plan:
- Store word 0xDEADBEEF at addr 0x1FE, then load word from 0x1FE, unsigned.
  - RAM bytes 0x1FE..0x201 = EF,BE,AD,DE, crossing the bank0/bank1 boundary.
  - Load returns resp_rdata=0xDEADBEEF at T+7.
- Store byte 0x80 at addr 0x400.
  - Load byte signed -> 0xFFFFFF80.
  - Load byte unsigned -> 0x00000080.
  - Store response at T+2.
- Store half 0x8001 at addr 0x3FF (misaligned).
  - Load half signed -> 0xFFFF8001.
  - Exactly two WE_c pulses, with WADDR_c=0x3FF then 0x400.
- Out-of-range and illegal requests:
  - Load word at addr 0x5FD (last byte 0x600) -> resp_err=1 at T+1, no RE_c pulse.
  - req_size=11 at addr 0 -> resp_err=1 at T+1, no RAM strobes.
- Back-to-back and ignored requests:
  - Back-to-back word loads with req_valid held high: second accept occurs in the cycle after the first resp_valid.
  - req_valid pulsed during ISSUE is not accepted.
- Reset mid-operation:
  - Assert RESET_N_c low during the 2nd issue cycle of a word store: WE_c=0 immediately, no resp_valid.
  - After release, req_ready=1 and a fresh byte load completes normally.
